// File: rtl/mont_exp_ctrl_if.sv
// Request/response and multiplier handshake bundle for mont_exp_ctrl.
// master = requester + multiplier side, slave = controller side.
interface mont_exp_ctrl_if #(
   parameter int N      = 512,
   parameter int E_WIDTH = 512,
   parameter int ELEN_W = 10
);
   logic                start;
   logic [N-1:0]        in_x;
   logic [E_WIDTH-1:0]  in_e;
   logic [ELEN_W-1:0]   e_len;
   logic [N-1:0]        in_m;
   logic [N-1:0]        in_r;
   logic [N-1:0]        in_r2;
   logic                busy;
   logic                done;
   logic [N-1:0]        result;
   logic                mul_start;
   logic [N-1:0]        mul_a;
   logic [N-1:0]        mul_b;
   logic [N-1:0]        mul_m;
   logic [N-1:0]        mul_result;
   logic                mul_done;

   modport master (
      output start, in_x, in_e, e_len, in_m, in_r, in_r2,
      output mul_result, mul_done,
      input  busy, done, result,
      input  mul_start, mul_a, mul_b, mul_m
   );

   modport slave (
      input  start, in_x, in_e, e_len, in_m, in_r, in_r2,
      input  mul_result, mul_done,
      output busy, done, result,
      output mul_start, mul_a, mul_b, mul_m
   );
endinterface

// File: rtl/mont_exp_ctrl.sv
// Left-to-right binary modular exponentiation sequencer that drives
// an external Montgomery multiplier over a start/done handshake.
module mont_exp_ctrl #(
   parameter int N       = 512,
   parameter int E_WIDTH = 512,
   parameter int ELEN_W  = 10
) (
   input logic            clk,
   input logic            reset,
   mont_exp_ctrl_if.slave bus
);

   typedef enum logic [3:0] {
      IDLE,
      ISSUE_TOM,
      WAIT_TOM,
      ISSUE_SQR,
      WAIT_SQR,
      ISSUE_MUL,
      WAIT_MUL,
      ISSUE_FROM,
      WAIT_FROM,
      DONE
   } state_t;

   localparam logic [N-1:0]      ONE  = N'(1);
   localparam logic [ELEN_W-1:0] EMAX = ELEN_W'(E_WIDTH);
   localparam logic [ELEN_W-1:0] DEC  = ELEN_W'(1);

   state_t              state_q;
   logic [E_WIDTH-1:0]  e_q;
   logic [N-1:0]        m_q;
   logic [N-1:0]        a_q;
   logic [N-1:0]        xm_q;
   logic [ELEN_W-1:0]   i_q;
   logic                busy_q;
   logic                done_q;
   logic [N-1:0]        res_q;
   logic                ms_q;
   logic [N-1:0]        ma_q;
   logic [N-1:0]        mb_q;

   logic                last;
   logic                e_bit;
   logic [ELEN_W-1:0]   len_clamp;

   assign last      = (i_q == '0);
   assign e_bit     = |(e_q & (E_WIDTH'(1) << i_q));
   assign len_clamp = (bus.e_len > EMAX) ? EMAX : bus.e_len;

   // Operands are registered together with the pulse so they hold
   // unchanged for the whole multiplier round trip.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         e_q     <= '0;
         m_q     <= '0;
         a_q     <= '0;
         xm_q    <= '0;
         i_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         res_q   <= '0;
         ms_q    <= 1'b0;
         ma_q    <= '0;
         mb_q    <= '0;
      end else begin
         ms_q   <= 1'b0;
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  e_q     <= bus.in_e;
                  m_q     <= bus.in_m;
                  a_q     <= bus.in_r;
                  i_q     <= len_clamp;
                  ma_q    <= bus.in_x;
                  mb_q    <= bus.in_r2;
                  ms_q    <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= ISSUE_TOM;
               end
            end
            ISSUE_TOM:  state_q <= WAIT_TOM;
            ISSUE_SQR:  state_q <= WAIT_SQR;
            ISSUE_MUL:  state_q <= WAIT_MUL;
            ISSUE_FROM: state_q <= WAIT_FROM;
            WAIT_TOM: begin
               if (bus.mul_done) begin
                  xm_q <= bus.mul_result;
                  ms_q <= 1'b1;
                  ma_q <= a_q;
                  if (last) begin
                     mb_q    <= ONE;
                     state_q <= ISSUE_FROM;
                  end else begin
                     mb_q    <= a_q;
                     i_q     <= i_q - DEC;
                     state_q <= ISSUE_SQR;
                  end
               end
            end
            WAIT_SQR: begin
               if (bus.mul_done) begin
                  a_q  <= bus.mul_result;
                  ms_q <= 1'b1;
                  ma_q <= bus.mul_result;
                  if (e_bit) begin
                     mb_q    <= xm_q;
                     state_q <= ISSUE_MUL;
                  end else if (last) begin
                     mb_q    <= ONE;
                     state_q <= ISSUE_FROM;
                  end else begin
                     mb_q    <= bus.mul_result;
                     i_q     <= i_q - DEC;
                     state_q <= ISSUE_SQR;
                  end
               end
            end
            WAIT_MUL: begin
               if (bus.mul_done) begin
                  a_q  <= bus.mul_result;
                  ms_q <= 1'b1;
                  ma_q <= bus.mul_result;
                  if (last) begin
                     mb_q    <= ONE;
                     state_q <= ISSUE_FROM;
                  end else begin
                     mb_q    <= bus.mul_result;
                     i_q     <= i_q - DEC;
                     state_q <= ISSUE_SQR;
                  end
               end
            end
            WAIT_FROM: begin
               if (bus.mul_done) begin
                  a_q     <= bus.mul_result;
                  res_q   <= bus.mul_result;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= DONE;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.result    = res_q;
   assign bus.mul_start = ms_q;
   assign bus.mul_a     = ma_q;
   assign bus.mul_b     = mb_q;
   assign bus.mul_m     = m_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Scoreboard bench for mont_exp_ctrl with a behavioural
// Montgomery multiplier of programmable latency.
module tb_mont_exp_ctrl;
   localparam int N  = 8;
   localparam int EW = 8;
   localparam int LW = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mont_exp_ctrl_if #(.N(N), .E_WIDTH(EW), .ELEN_W(LW)) ifc ();

   mont_exp_ctrl #(.N(N), .E_WIDTH(EW), .ELEN_W(LW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave)
   );

   int total = 0;
   int bad   = 0;
   int lat   = 3;
   logic [7:0] cur_m = 8'd13;

   typedef struct {
      logic [7:0] res;
      int         pulses;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      logic [7:0] res;
      int         pulses;
      int         lat_bad;
      int         dn_bad;
      int         stab_bad;
      int         busy_bad;
      logic       busy;
   } obs_t;
   obs_t obs[0:63];
   int   n_obs = 0;
   int   rd    = 0;
   int   mon_ms = 0;

   function automatic int mm(int a, int b, int m);
      int t;
      t = a * b;
      for (int k = 0; k < 8; k++) begin
         if (t % 2 == 1) t = t + m;
         t = t / 2;
      end
      if (t >= m) t = t - m;
      return t;
   endfunction

   function automatic int modpow(int x, int e, int l, int m);
      int r;
      r = 1 % m;
      for (int k = l - 1; k >= 0; k--) begin
         r = (r * r) % m;
         if (((e >> k) & 1) == 1) r = (r * x) % m;
      end
      return r;
   endfunction

   // behavioural multiplier
   logic       pend = 1'b0;
   int         cnt  = 0;
   logic [7:0] pa, pb, pm;
   always @(posedge clk) begin
      ifc.mul_done <= 1'b0;
      if (ifc.mul_start) begin
         if (lat <= 1) begin
            ifc.mul_done   <= 1'b1;
            ifc.mul_result <= 8'(mm(ifc.mul_a, ifc.mul_b, cur_m));
         end else begin
            pend <= 1'b1;
            cnt  <= lat - 1;
            pa   <= ifc.mul_a;
            pb   <= ifc.mul_b;
            pm   <= cur_m;
         end
      end else if (pend) begin
         if (cnt == 1) begin
            ifc.mul_done   <= 1'b1;
            ifc.mul_result <= 8'(mm(pa, pb, pm));
            pend           <= 1'b0;
         end else begin
            cnt <= cnt - 1;
         end
      end
   end

   // monitor: collects one observation record per done pulse
   initial begin
      int cyc, exp_ms, exp_dn, lat_bad, dn_bad, stab_bad, busy_bad;
      logic waiting, in_op;
      logic [7:0] ha, hb;
      cyc = 0; exp_ms = -1; exp_dn = -1;
      lat_bad = 0; dn_bad = 0; stab_bad = 0; busy_bad = 0;
      waiting = 1'b0; in_op = 1'b0; ha = '0; hb = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            waiting = 1'b0;
            in_op   = 1'b0;
         end else begin
            if (in_op && !ifc.done && !ifc.busy) busy_bad++;
            if (ifc.start && !ifc.busy && !ifc.done) begin
               in_op = 1'b1; mon_ms = 0; exp_ms = cyc + 1; exp_dn = -1;
               lat_bad = 0; dn_bad = 0; stab_bad = 0; busy_bad = 0;
            end
            if (ifc.mul_start) begin
               mon_ms++;
               if (cyc != exp_ms) lat_bad++;
               if (ifc.mul_m !== cur_m) stab_bad++;
               ha = ifc.mul_a; hb = ifc.mul_b; waiting = 1'b1;
            end else if (waiting) begin
               if (ifc.mul_a !== ha || ifc.mul_b !== hb) stab_bad++;
            end
            if (ifc.mul_done && waiting) begin
               waiting = 1'b0; exp_ms = cyc + 1; exp_dn = cyc + 1;
            end
            if (ifc.done && in_op) begin
               if (cyc != exp_dn) dn_bad = 1;
               if (n_obs < 64)
                  obs[n_obs] = '{ifc.result, mon_ms, lat_bad, dn_bad,
                                 stab_bad, busy_bad, ifc.busy};
               n_obs++;
               in_op = 1'b0;
            end
         end
      end
   end

   task automatic push_exp(input int x, input int e, input int len,
                           input int m);
      int l, pc;
      exp_t ex;
      l  = (len > EW) ? EW : len;
      pc = 0;
      for (int k = 0; k < l; k++) pc += (e >> k) & 1;
      ex.res    = 8'(modpow(x, e, l, m));
      ex.pulses = 2 + l + pc;
      exp_q.push_back(ex);
   endtask

   task automatic set_inputs(input int x, input int e, input int len,
                             input int m);
      int r;
      r = 256 % m;
      cur_m     = 8'(m);
      ifc.in_x  = 8'(x);
      ifc.in_e  = 8'(e);
      ifc.e_len = 4'(len);
      ifc.in_m  = 8'(m);
      ifc.in_r  = 8'(r);
      ifc.in_r2 = 8'((r * r) % m);
   endtask

   task automatic scramble();
      ifc.in_x  = 8'($urandom);
      ifc.in_e  = 8'($urandom);
      ifc.e_len = 4'($urandom);
      ifc.in_m  = 8'($urandom);
      ifc.in_r  = 8'($urandom);
      ifc.in_r2 = 8'($urandom);
   endtask

   task automatic do_start(input int x, input int e, input int len,
                           input int m);
      push_exp(x, e, len, m);
      @(posedge clk); #2;
      set_inputs(x, e, len, m);
      ifc.start = 1'b1;
      @(posedge clk); #2;
      ifc.start = 1'b0;
      scramble();
   endtask

   task automatic check_op(input string nm, input int budget);
      int   k;
      exp_t ex;
      obs_t ob;
      k = 0;
      while (n_obs <= rd && k < budget) begin
         @(posedge clk); #2;
         k++;
      end
      ex = exp_q.pop_front();
      total++;
      if (n_obs <= rd) begin
         bad++;
         $display("FAIL %s timeout: no done within %0d cycles", nm, budget);
         return;
      end
      ob = obs[rd];
      rd++;
      total++;
      if (ob.res !== ex.res) begin
         bad++;
         $display("FAIL %s result: got %0d want %0d", nm, ob.res, ex.res);
      end
      total++;
      if (ob.pulses != ex.pulses) begin
         bad++;
         $display("FAIL %s pulses: got %0d want %0d", nm, ob.pulses,
                  ex.pulses);
      end
      total++;
      if (ob.lat_bad != 0) begin
         bad++;
         $display("FAIL %s mul_start latency: %0d late pulses want 0", nm,
                  ob.lat_bad);
      end
      total++;
      if (ob.dn_bad != 0) begin
         bad++;
         $display("FAIL %s done latency: got %0d want 0", nm, ob.dn_bad);
      end
      total++;
      if (ob.stab_bad != 0) begin
         bad++;
         $display("FAIL %s operand stability: %0d changes want 0", nm,
                  ob.stab_bad);
      end
      total++;
      if (ob.busy_bad != 0 || ob.busy !== 1'b0) begin
         bad++;
         $display("FAIL %s busy: %0d gaps, busy@done=%b want 0/0", nm,
                  ob.busy_bad, ob.busy);
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      ifc.start = 1'b0;
      set_inputs(0, 0, 0, 13);
      repeat (3) @(posedge clk);
      #2;
      total++;
      if ({ifc.busy, ifc.done, ifc.mul_start} !== 3'b000) begin
         bad++;
         $display("FAIL reset flags: got %b want 000",
                  {ifc.busy, ifc.done, ifc.mul_start});
      end
      total++;
      if (ifc.result !== 8'd0) begin
         bad++;
         $display("FAIL reset result: got %0d want 0", ifc.result);
      end
      total++;
      if ({ifc.mul_a, ifc.mul_b, ifc.mul_m} !== 24'd0) begin
         bad++;
         $display("FAIL reset operands: got %h want 0",
                  {ifc.mul_a, ifc.mul_b, ifc.mul_m});
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      lat = 3;
      do_start(2, 5, 3, 13);
      repeat (4) @(posedge clk);
      #2;
      ifc.in_x  = 8'd3;
      ifc.in_e  = 8'hFF;
      ifc.e_len = 4'd8;
      ifc.start = 1'b1;
      @(posedge clk); #2;
      ifc.start = 1'b0;
      check_op("basic", 300);
      repeat (30) @(posedge clk);
      #2;
      total++;
      if (n_obs != rd) begin
         bad++;
         $display("FAIL busy_start extra done: got %0d want %0d", n_obs, rd);
      end
   endtask

   task automatic test_zero_exp();
      lat = 3;
      do_start(2, 0, 0, 13);
      check_op("zero_exp", 300);
   endtask

   task automatic test_full_exp();
      int lats[3] = '{3, 1, 200};
      foreach (lats[k]) begin
         lat = lats[k];
         do_start(2, 'hFF, 8, 13);
         check_op($sformatf("full_lat%0d", lats[k]), 6000);
      end
      lat = 3;
   endtask

   task automatic test_clamp();
      lat = 3;
      do_start(2, 'hFF, 12, 13);
      check_op("clamp", 600);
   endtask

   task automatic test_midreset();
      int   k;
      exp_t ex;
      lat = 3;
      do_start(2, 5, 3, 13);
      k = 0;
      while (!(mon_ms == 4 && !ifc.mul_start) && k < 200) begin
         @(posedge clk); #2;
         k++;
      end
      total++;
      if (k >= 200) begin
         bad++;
         $display("FAIL midreset wait: got %0d pulses want 4", mon_ms);
      end
      reset = 1'b1;
      #1;
      ex = exp_q.pop_back();
      total++;
      if ({ifc.busy, ifc.done, ifc.mul_start} !== 3'b000) begin
         bad++;
         $display("FAIL midreset flags: got %b want 000",
                  {ifc.busy, ifc.done, ifc.mul_start});
      end
      @(posedge clk); #2;
      reset = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      total++;
      if ({ifc.busy, ifc.mul_start} !== 2'b00 || ifc.result !== 8'd0
          || n_obs != rd) begin
         bad++;
         $display("FAIL late mul_done: busy=%b ms=%b res=%0d dones=%0d want 0 0 0 %0d",
                  ifc.busy, ifc.mul_start, ifc.result, n_obs, rd);
      end
      do_start(2, 5, 3, 13);
      check_op("after_reset", 300);
   endtask

   task automatic test_back_to_back();
      int k;
      lat = 3;
      do_start(2, 5, 3, 13);
      k = 0;
      while (!ifc.done && k < 300) begin
         @(posedge clk); #2;
         k++;
      end
      push_exp(5, 13, 4, 13);
      set_inputs(5, 13, 4, 13);
      ifc.start = 1'b1;
      @(posedge clk); #2;
      total++;
      if (ifc.busy !== 1'b0) begin
         bad++;
         $display("FAIL done_cycle start: busy=%b want 0", ifc.busy);
      end
      @(posedge clk); #2;
      ifc.start = 1'b0;
      scramble();
      check_op("b2b_first", 300);
      check_op("b2b_second", 300);
   endtask

   task automatic test_random();
      int m, x, e, len;
      for (int n = 0; n < 6; n++) begin
         lat = 1 + n;
         m   = 2 * $urandom_range(1, 127) + 1;
         x   = $urandom_range(0, m - 1);
         e   = $urandom_range(0, 255);
         len = $urandom_range(0, 10);
         do_start(x, e, len, m);
         check_op($sformatf("rand%0d", n), 1000);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_exp();
      test_full_exp();
      test_clamp();
      test_midreset();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
